// File: rtl/vdp_cpu_read_port.sv
// VDP CPU-read responder for ports 0x80/0x81: read-ahead VRAM buffer, status
// snapshot, vertical-blank frame flag, /INT generation and VRAM prefetch FSM.
module vdp_cpu_read_port #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              hwclk,
    input  logic              reset_n,
    input  logic              rd_sel_n,
    input  logic              a0,
    output logic [7:0]        rd_data,
    input  logic              frame_tick,
    input  logic              coinc,
    input  logic              ie,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              vram_req,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    output logic              latch_clr,
    output logic              int_n,
    output logic [7:0]        status_out
);

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    logic [SYNC_STAGES-1:0] r_sel_sync;
    logic [SYNC_STAGES-1:0] r_a0_sync;
    logic                   r_sel_hist;
    logic                   r_cyc_a0;
    logic [7:0]             r_status_snap;
    logic                   r_frame_flag;
    logic                   r_latch_clr;
    logic                   r_int_n;
    logic [ADDR_W-1:0]      r_ptr;

    state_t                 r_state;
    logic                   r_vram_req;
    logic [ADDR_W-1:0]      r_vram_addr;
    logic [7:0]             r_read_buf;
    logic                   r_pend;
    logic [ADDR_W-1:0]      r_pend_addr;
    logic                   r_discard;

    logic                   w_sel_s;
    logic                   w_a0_s;
    logic                   w_sel_fall;
    logic                   w_sel_rise;
    logic                   w_stat_end;
    logic                   w_data_end;
    logic                   w_start;
    logic [ADDR_W-1:0]      w_start_addr;
    logic [7:0]             w_status;

    assign w_sel_s      = r_sel_sync[SYNC_STAGES-1];
    assign w_a0_s       = r_a0_sync[SYNC_STAGES-1];
    assign w_sel_fall   = r_sel_hist & ~w_sel_s;
    assign w_sel_rise   = ~r_sel_hist & w_sel_s;
    assign w_stat_end   = w_sel_rise & r_cyc_a0;
    assign w_data_end   = w_sel_rise & ~r_cyc_a0;
    // A pointer load takes priority over a coincident data-read-end prefetch.
    assign w_start      = addr_load | w_data_end;
    assign w_start_addr = addr_load ? addr_in : r_ptr;
    assign w_status     = {r_frame_flag, 1'b0, coinc, 5'b0};

    assign rd_data    = a0 ? r_status_snap : r_read_buf;
    assign status_out = w_status;
    assign vram_req   = r_vram_req;
    assign vram_addr  = r_vram_addr;
    assign latch_clr  = r_latch_clr;
    assign int_n      = r_int_n;

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_sel_sync    <= '1;
            r_a0_sync     <= '0;
            r_sel_hist    <= 1'b1;
            r_cyc_a0      <= 1'b0;
            r_status_snap <= '0;
            r_frame_flag  <= 1'b0;
            r_latch_clr   <= 1'b0;
            r_int_n       <= 1'b1;
            r_ptr         <= '0;
        end else begin
            r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], rd_sel_n};
            r_a0_sync  <= {r_a0_sync[SYNC_STAGES-2:0], a0};
            r_sel_hist <= w_sel_s;

            if (w_sel_fall) begin
                r_cyc_a0 <= w_a0_s;
            end
            if (w_sel_fall && w_a0_s) begin
                r_status_snap <= w_status;
            end

            if (frame_tick) begin
                r_frame_flag <= 1'b1;
            end else if (w_stat_end) begin
                r_frame_flag <= 1'b0;
            end

            r_latch_clr <= w_stat_end;
            r_int_n     <= ~(r_frame_flag & ie);

            if (w_start) begin
                r_ptr <= w_start_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_vram_req  <= 1'b0;
            r_vram_addr <= '0;
            r_read_buf  <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_discard   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_vram_addr <= w_start_addr;
                        r_vram_req  <= 1'b1;
                        r_pend      <= 1'b0;
                        r_state     <= ST_REQ;
                    end else if (r_pend) begin
                        r_vram_addr <= r_pend_addr;
                        r_vram_req  <= 1'b1;
                        r_pend      <= 1'b0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_start) begin
                        r_pend      <= 1'b1;
                        r_pend_addr <= w_start_addr;
                    end
                    // A load during an outstanding fetch makes that fetch stale.
                    if (addr_load) begin
                        r_discard <= 1'b1;
                    end
                    if (vram_ack) begin
                        if (!r_discard && !addr_load) begin
                            r_read_buf <= vram_rdata;
                        end
                        r_vram_req <= 1'b0;
                        r_discard  <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_vram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_cpu_read_port.sv
// Directed self-checking bench for vdp_cpu_read_port with a simple VRAM arbiter responder.
module tb_vdp_cpu_read_port;

    localparam int unsigned AW = 14;

    logic          hwclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_sel_n = 1'b1;
    logic          a0 = 1'b0;
    logic [7:0]    rd_data;
    logic          frame_tick = 1'b0;
    logic          coinc = 1'b0;
    logic          ie = 1'b0;
    logic          addr_load = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          vram_req;
    logic [AW-1:0] vram_addr;
    logic          vram_ack = 1'b0;
    logic [7:0]    vram_rdata = '0;
    logic          latch_clr;
    logic          int_n;
    logic [7:0]    status_out;

    int n_checks = 0;
    int n_fail = 0;

    logic          arb_en = 1'b1;
    int            ack_delay = 2;
    int            arb_cnt = 0;
    logic [AW-1:0] ack_log[$];

    vdp_cpu_read_port #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .hwclk(hwclk), .reset_n(reset_n), .rd_sel_n(rd_sel_n), .a0(a0),
        .rd_data(rd_data), .frame_tick(frame_tick), .coinc(coinc), .ie(ie),
        .addr_load(addr_load), .addr_in(addr_in), .vram_req(vram_req),
        .vram_addr(vram_addr), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .latch_clr(latch_clr), .int_n(int_n), .status_out(status_out)
    );

    always #5 hwclk = ~hwclk;

    function automatic logic [7:0] f_data(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Arbiter: acks a request after ack_delay low-phase samples, logs each served address.
    always @(negedge hwclk) begin
        if (vram_ack) begin
            vram_ack = 1'b0;
        end else if (arb_en && vram_req) begin
            if (arb_cnt >= ack_delay) begin
                vram_ack   = 1'b1;
                vram_rdata = f_data(vram_addr);
                ack_log.push_back(vram_addr);
                arb_cnt    = 0;
            end else begin
                arb_cnt++;
            end
        end else begin
            arb_cnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic do_load(input logic [AW-1:0] a);
        addr_in   = a;
        addr_load = 1'b1;
        @(negedge hwclk);
        addr_load = 1'b0;
    endtask

    task automatic wait_acks(input int n, output logic ok);
        int cyc;
        cyc = 0;
        while (ack_log.size() < n && cyc < 200) begin
            @(negedge hwclk);
            cyc++;
        end
        ok = (ack_log.size() >= n);
        @(negedge hwclk);
    endtask

    task automatic cpu_read(input logic sel_a0, input int low, input logic tick_end,
                            input logic coinc_mid, output logic [7:0] data,
                            output logic stable, output int lc);
        logic [7:0] first;
        first    = '0;
        a0       = sel_a0;
        rd_sel_n = 1'b0;
        stable   = 1'b1;
        lc       = 0;
        for (int i = 1; i <= low; i++) begin
            @(negedge hwclk);
            if (i == 3) first = rd_data;
            else if (i > 3 && rd_data !== first) stable = 1'b0;
            if (coinc_mid && i == 4) coinc = 1'b1;
        end
        data     = rd_data;
        rd_sel_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge hwclk);
            frame_tick = tick_end && (i == 1);
            if (latch_clr === 1'b1) lc++;
        end
        a0 = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(10);
        a0 = 1'b1;
        #1;
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_status: got %h, want 00", rd_data); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL reset_int_n: got %b, want 1", int_n); end
        n_checks++; if (vram_req !== 1'b0) begin n_fail++; $display("FAIL reset_vram_req: got %b, want 0", vram_req); end
        n_checks++; if (status_out !== 8'h00) begin n_fail++; $display("FAIL reset_status_out: got %h, want 00", status_out); end
        n_checks++; if (latch_clr !== 1'b0) begin n_fail++; $display("FAIL reset_latch_clr: got %b, want 0", latch_clr); end
        a0 = 1'b0;
        #1;
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_buf: got %h, want 00", rd_data); end
        @(negedge hwclk);
    endtask

    task automatic test_frame_int;
        logic [7:0] d; logic st; int lc;
        ie = 1'b1;
        frame_tick = 1'b1;
        @(negedge hwclk);
        frame_tick = 1'b0;
        n_checks++; if (status_out !== 8'h80) begin n_fail++; $display("FAIL tick_flag: got %h, want 80", status_out); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL int_latency: got %b, want 1", int_n); end
        @(negedge hwclk);
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL int_assert: got %b, want 0", int_n); end
        frame_tick = 1'b1;
        tick(2);
        frame_tick = 1'b0;
        n_checks++; if (status_out !== 8'h80) begin n_fail++; $display("FAIL tick_idempotent: got %h, want 80", status_out); end
        cpu_read(1'b1, 6, 1'b0, 1'b1, d, st, lc);
        n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL status_read: got %h, want 80", d); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL status_stable: got %b, want 1", st); end
        n_checks++; if (lc !== 1) begin n_fail++; $display("FAIL latch_clr_pulse: got %0d, want 1", lc); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL int_clear: got %b, want 1", int_n); end
        n_checks++; if (status_out !== 8'h20) begin n_fail++; $display("FAIL status_after_read: got %h, want 20", status_out); end
        a0 = 1'b1;
        #1;
        n_checks++; if (rd_data !== 8'h80) begin n_fail++; $display("FAIL snap_held: got %h, want 80", rd_data); end
        a0 = 1'b0;
        coinc = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic test_coincident_tick;
        logic [7:0] d; logic st; int lc;
        ie = 1'b1;
        frame_tick = 1'b1;
        @(negedge hwclk);
        frame_tick = 1'b0;
        tick(2);
        cpu_read(1'b1, 6, 1'b1, 1'b0, d, st, lc);
        n_checks++; if (d !== 8'h80) begin n_fail++; $display("FAIL coin_read: got %h, want 80", d); end
        n_checks++; if (lc !== 1) begin n_fail++; $display("FAIL coin_latch_clr: got %0d, want 1", lc); end
        n_checks++; if (status_out !== 8'h80) begin n_fail++; $display("FAIL coin_flag_kept: got %h, want 80", status_out); end
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL coin_int_n: got %b, want 0", int_n); end
        cpu_read(1'b1, 6, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (status_out !== 8'h00) begin n_fail++; $display("FAIL coin_second_clear: got %h, want 00", status_out); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL coin_int_release: got %b, want 1", int_n); end
    endtask

    task automatic test_ie_mask;
        logic [7:0] d; logic st; int lc;
        ie = 1'b0;
        frame_tick = 1'b1;
        @(negedge hwclk);
        frame_tick = 1'b0;
        tick(2);
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL ie_off_int: got %b, want 1", int_n); end
        ie = 1'b1;
        tick(2);
        n_checks++; if (int_n !== 1'b0) begin n_fail++; $display("FAIL ie_on_int: got %b, want 0", int_n); end
        ie = 1'b0;
        tick(2);
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL ie_clear_int: got %b, want 1", int_n); end
        n_checks++; if (status_out !== 8'h80) begin n_fail++; $display("FAIL ie_clear_flag: got %h, want 80", status_out); end
        cpu_read(1'b1, 6, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (status_out !== 8'h00) begin n_fail++; $display("FAIL ie_read_clear: got %h, want 00", status_out); end
    endtask

    task automatic test_wrap;
        logic [7:0] d; logic st; int lc; int base; logic ok;
        ack_delay = 3;
        base = ack_log.size();
        do_load(14'h3FFF);
        n_checks++; if (vram_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req_latency: got %b, want 1", vram_req); end
        n_checks++; if (vram_addr !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_vram_addr: got %h, want 3fff", vram_addr); end
        wait_acks(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_ack1_timeout: acks %0d, want %0d", ack_log.size(), base + 1); end
        n_checks++; if (ok && ack_log[base] !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_addr1: got %h, want 3fff", ack_log[base]); end
        n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL wrap_read_buf: got %h, want 5a", rd_data); end
        cpu_read(1'b0, 6, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL wrap_data_read: got %h, want 5a", d); end
        n_checks++; if (lc !== 0) begin n_fail++; $display("FAIL wrap_no_latch_clr: got %0d, want 0", lc); end
        wait_acks(base + 2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_ack2_timeout: acks %0d, want %0d", ack_log.size(), base + 2); end
        n_checks++; if (ok && ack_log[base+1] !== 14'h0000) begin n_fail++; $display("FAIL wrap_addr2: got %h, want 0000", ack_log[base+1]); end
        n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL wrap_read_buf2: got %h, want a5", rd_data); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d; logic st; int lc; int base; logic ok; logic [AW-1:0] a;
        ack_delay = 2;
        base = ack_log.size();
        do_load(14'h0100);
        wait_acks(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_load_timeout: acks %0d, want %0d", ack_log.size(), base + 1); end
        for (int k = 0; k < 8; k++) begin
            a = 14'h0100 + 14'(k);
            cpu_read(1'b0, 6, 1'b0, 1'b0, d, st, lc);
            n_checks++; if (d !== f_data(a)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h, want %h", k, d, f_data(a)); end
            wait_acks(base + 2 + k, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout[%0d]: acks %0d, want %0d", k, ack_log.size(), base + 2 + k); end
        end
        tick(5);
        n_checks++; if (ack_log.size() !== base + 9) begin n_fail++; $display("FAIL b2b_count: got %0d, want %0d", ack_log.size() - base, 9); end
        for (int j = 0; j < 9; j++) begin
            a = 14'h0100 + 14'(j);
            if (base + j < ack_log.size()) begin
                n_checks++; if (ack_log[base+j] !== a) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h, want %h", j, ack_log[base+j], a); end
            end
        end
    endtask

    task automatic test_overlap;
        logic [7:0] d; logic st; int lc; int base; logic ok;
        ack_delay = 10;
        base = ack_log.size();
        do_load(14'h0200);
        cpu_read(1'b0, 3, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (d !== 8'hAD) begin n_fail++; $display("FAIL ovl_stale_data: got %h, want ad", d); end
        wait_acks(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovl_ack1_timeout: acks %0d, want %0d", ack_log.size(), base + 1); end
        n_checks++; if (ok && ack_log[base] !== 14'h0200) begin n_fail++; $display("FAIL ovl_addr1: got %h, want 0200", ack_log[base]); end
        n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL ovl_buf1: got %h, want a5", rd_data); end
        wait_acks(base + 2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovl_ack2_timeout: acks %0d, want %0d", ack_log.size(), base + 2); end
        n_checks++; if (ok && ack_log[base+1] !== 14'h0201) begin n_fail++; $display("FAIL ovl_addr2: got %h, want 0201", ack_log[base+1]); end
        n_checks++; if (rd_data !== 8'hA4) begin n_fail++; $display("FAIL ovl_buf2: got %h, want a4", rd_data); end
    endtask

    task automatic test_load_discard;
        logic [7:0] d; logic st; int lc; int base; logic ok;
        ack_delay = 10;
        base = ack_log.size();
        do_load(14'h0300);
        tick(2);
        do_load(14'h0310);
        wait_acks(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL disc_ack1_timeout: acks %0d, want %0d", ack_log.size(), base + 1); end
        n_checks++; if (ok && ack_log[base] !== 14'h0300) begin n_fail++; $display("FAIL disc_addr1: got %h, want 0300", ack_log[base]); end
        n_checks++; if (rd_data !== 8'hA4) begin n_fail++; $display("FAIL disc_buf_kept: got %h, want a4", rd_data); end
        wait_acks(base + 2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL disc_ack2_timeout: acks %0d, want %0d", ack_log.size(), base + 2); end
        n_checks++; if (ok && ack_log[base+1] !== 14'h0310) begin n_fail++; $display("FAIL disc_addr2: got %h, want 0310", ack_log[base+1]); end
        n_checks++; if (rd_data !== 8'hB5) begin n_fail++; $display("FAIL disc_buf_new: got %h, want b5", rd_data); end
        cpu_read(1'b0, 6, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (d !== 8'hB5) begin n_fail++; $display("FAIL disc_data_read: got %h, want b5", d); end
        wait_acks(base + 3, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL disc_ack3_timeout: acks %0d, want %0d", ack_log.size(), base + 3); end
        n_checks++; if (ok && ack_log[base+2] !== 14'h0311) begin n_fail++; $display("FAIL disc_addr3: got %h, want 0311", ack_log[base+2]); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d; logic st; int lc; int base; logic ok;
        arb_en = 1'b0;
        ack_delay = 2;
        base = ack_log.size();
        do_load(14'h1234);
        n_checks++; if (vram_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre: got %b, want 1", vram_req); end
        tick(1);
        do_load(14'h1300);
        reset_n = 1'b0;
        @(negedge hwclk);
        n_checks++; if (vram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_drop: got %b, want 0", vram_req); end
        tick(2);
        reset_n = 1'b1;
        arb_en = 1'b1;
        tick(10);
        n_checks++; if (ack_log.size() !== base) begin n_fail++; $display("FAIL rst_spurious: got %0d acks, want %0d", ack_log.size(), base); end
        n_checks++; if (vram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_idle: got %b, want 0", vram_req); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_read_buf: got %h, want 00", rd_data); end
        n_checks++; if (int_n !== 1'b1) begin n_fail++; $display("FAIL rst_int_n: got %b, want 1", int_n); end
        cpu_read(1'b0, 6, 1'b0, 1'b0, d, st, lc);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_data_read: got %h, want 00", d); end
        wait_acks(base + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_ack_timeout: acks %0d, want %0d", ack_log.size(), base + 1); end
        n_checks++; if (ok && ack_log[base] !== 14'h0000) begin n_fail++; $display("FAIL rst_ptr_zero: got %h, want 0000", ack_log[base]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge hwclk);
        test_reset;
        test_frame_int;
        test_coincident_tick;
        test_ie_mask;
        test_wrap;
        test_back_to_back;
        test_overlap;
        test_load_discard;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vdp_cpu_read_port.md
Name: vdp_cpu_read_port

Overview:
- CPU-read responder for the VDP I/O pair 0x80/0x81, running in the hwclk domain alongside the VDP raster engine.
- Port 0x80 (a0=0) returns VRAM data through a read-ahead buffer. Port 0x81 (a0=1) returns the status register.
- Owns the vertical-blank frame flag and the /INT request.
- Issues VRAM prefetch requests to the VRAM arbiter, and tells the CPU write side when to clear its two-byte command latch.

Parameters:
ADDR_W, 14, VRAM address pointer width
SYNC_STAGES, 2, flip-flop stages on asynchronous CPU inputs (min 2)

Ports:
hwclk  in  1  system clock
reset_n  in  1  synchronous active-low reset
rd_sel_n  in  1  async, low while the CPU reads 0x80/0x81 (IORQ&RD&decode, qualified upstream)
a0  in  1  async CPU address bit 0
rd_data  out  8  byte presented to the CPU data bus: status_snap when a0=1, else read_buf (combinational mux on raw a0)
frame_tick  in  1  one-hwclk pulse at start of vertical blank, from raster engine
coinc  in  1  sprite coincidence level from raster engine
ie  in  1  frame interrupt enable (VDP reg 1 bit 5)
addr_load  in  1  pulse: load pointer and prefetch (from write side, read-setup command)
addr_in  in  ADDR_W  pointer load value
vram_req  out  1  prefetch request
vram_addr  out  ADDR_W  prefetch address
vram_ack  in  1  one-cycle pulse: vram_rdata valid this cycle
vram_rdata  in  8  VRAM read data
latch_clr  out  1  one-cycle pulse: clear the write-side first-byte flag
int_n  out  1  active-low interrupt to CPU
status_out  out  8  current live status, for debug/LEDs

Behaviour:
Reset:
- read_buf=0, status_snap=0, frame_flag=0, ptr=0.
- vram_req=0, latch_clr=0, int_n=1, FSM=IDLE.
- Synchronizer stages preset to 1 (rd_sel_n) and 0 (a0).

Synchronizer and edge detect:
- rd_sel_n and a0 pass through SYNC_STAGES flops, plus one history flop.
- sel_fall marks read start; sel_rise marks read end. Each is one cycle.
- The a0 value captured at sel_fall is held as cyc_a0 until sel_rise.

Status format:
- {frame_flag, 1'b0, coinc, 5'b0}. status_out is this value, live.
- At sel_fall with synced a0=1, status_snap loads the live status. It is not updated again until the next status-read start, so rd_data is stable for the whole read.

Status read end (sel_rise, cyc_a0=1):
- frame_flag<=0.
- latch_clr pulses one cycle.
- If frame_tick occurs the same cycle, set wins: frame_flag=1.

Data read end (sel_rise, cyc_a0=0):
- Start a prefetch at ptr, then ptr<=ptr+1, wrapping modulo 2^ADDR_W (0x3FFF+1 -> 0).

addr_load:
- ptr<=addr_in, then a prefetch is started at the loaded address, and ptr increments as above.
- If addr_load coincides with a data-read end, addr_load wins and the read-end prefetch is discarded.

Prefetch FSM:
- IDLE: on a start request -> REQ; vram_addr<=ptr; vram_req<=1.
- REQ: hold vram_req and vram_addr until vram_ack. On ack: read_buf<=vram_rdata, vram_req<=0, -> IDLE.
- A start request arriving in REQ is recorded in a single pending bit, with its address captured. After the ack, the FSM returns to REQ next cycle for that request. A further request overwrites the pending one.
- addr_load while in REQ:
  - The current request completes.
  - Its data is discarded (read_buf is not written).
  - The loaded address is queued as pending.
- Latency: vram_req is asserted the cycle after the start event; read_buf is updated the cycle after vram_ack.

Interrupt:
- int_n = ~(frame_flag & ie), registered, 1 cycle after the flag changes.
- Clearing ie deasserts int_n but leaves frame_flag set.

frame_tick:
- Sets frame_flag and is idempotent.

Reset mid-operation:
- Aborts any request. vram_req drops in the cycle reset is sampled. Pending is cleared.

Test Plan:
1. Reset, then idle 10 cycles -> int_n=1, vram_req=0, rd_data with a0=1 reads 0x00, status_out=0x00.
2. frame_tick with ie=1 -> frame_flag set, int_n=0 next cycle. Status read (a0=1) -> rd_data=0x80 for the whole strobe. After sel_rise: latch_clr one pulse, int_n=1, status_out=0x00.
3. addr_load addr_in=0x3FFF, arbiter acks after 3 cycles with 0x5A -> vram_addr=0x3FFF, read_buf=0x5A. Data read returns 0x5A; the follow-up prefetch is at 0x0000 (wrap check).
4. Data read ends while a prefetch is still waiting for ack -> the first ack fills read_buf, then the second request is issued at the next address. No lost or duplicated addresses over 8 back-to-back reads at 0x0100..0x0107.
5. frame_tick coincides with the status-read-end cycle -> frame_flag remains 1, int_n stays 0, latch_clr still pulses.
6. reset_n low while vram_req=1 -> vram_req=0 on the next edge. After release, no spurious request, ptr=0, read_buf=0.
